// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] nibble_t;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } scan_phase_t;

  // Legal configuration: at least two digits, a slot of at least two cycles,
  // and a blanking window strictly shorter than the slot.
  function automatic bit cfg_ok(input int n_digits, input int clk_div, input int blank_cyc);
    return (n_digits >= 2) && (clk_div >= 2) && (blank_cyc >= 0) && (blank_cyc < clk_div);
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load handshake, display controls and decoder/digit drive for the scan controller.
interface seg7_scan_ctrl_if
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 4
);

  logic                          load_valid;
  logic                          load_ready;
  logic [DIGIT_W*N_DIGITS-1:0]   load_data;
  logic [N_DIGITS-1:0]           blank_mask;
  logic                          lz_suppress;
  nibble_t                       nibble_out;
  logic                          dec_blank;
  logic [N_DIGITS-1:0]           digit_en;
  logic                          frame_tick;

  modport master (
    output load_valid, load_data, blank_mask, lz_suppress,
    input  load_ready, nibble_out, dec_blank, digit_en, frame_tick
  );

  modport slave (
    input  load_valid, load_data, blank_mask, lz_suppress,
    output load_ready, nibble_out, dec_blank, digit_en, frame_tick
  );

endinterface

// File: rtl/seg7_scan_timer.sv
// Slot counter and digit index for the display scan; flags slot and frame ends.
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16,
  parameter int CW        = $clog2(CLK_DIV),
  parameter int IW        = $clog2(N_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [IW-1:0] idx,
  output logic          slot_last,
  output logic          frame_last,
  output scan_phase_t   phase
);

  logic [CW-1:0] cnt;

  assign slot_last  = (cnt == CW'(CLK_DIV - 1));
  assign frame_last = slot_last && (idx == IW'(N_DIGITS - 1));
  assign phase      = (int'(cnt) < BLANK_CYC) ? PH_BLANK : PH_SHOW;

  // Advance the slot counter every cycle and step to the next digit at slot end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// New values are staged in a pending register and only reach the displayed
// shadow at a frame boundary, so a frame never mixes old and new digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int IW = $clog2(N_DIGITS);
  localparam int VW = DIGIT_W * N_DIGITS;

  if (!cfg_ok(N_DIGITS, CLK_DIV, BLANK_CYC)) begin : g_bad_cfg
    $error("seg7_scan_ctrl: illegal N_DIGITS/CLK_DIV/BLANK_CYC combination");
  end

  logic [IW-1:0] idx;
  logic          slot_last;
  logic          frame_last;
  logic          boundary;
  scan_phase_t   phase;

  logic [VW-1:0] shadow;
  logic [VW-1:0] pending;
  logic          pending_v;
  logic          xfer;
  nibble_t       digit [N_DIGITS];
  logic          lz_cur;

  seg7_scan_timer #(
    .N_DIGITS  (N_DIGITS),
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .idx        (idx),
    .slot_last  (slot_last),
    .frame_last (frame_last),
    .phase      (phase)
  );

  assign boundary       = slot_last && frame_last;
  assign bus.load_ready = !pending_v;
  assign xfer           = bus.load_valid && !pending_v;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    assign digit[g] = shadow[g*DIGIT_W +: DIGIT_W];
  end

  // Leading zero: current digit and every higher digit are zero (digit 0 exempt).
  always_comb begin
    lz_cur = bus.lz_suppress && (idx != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if ((i >= int'(idx)) && (digit[i] != '0)) lz_cur = 1'b0;
    end
  end

  // Stage loads in the pending register and promote them at the frame boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      pending   <= '0;
      pending_v <= 1'b0;
    end else begin
      if (boundary && pending_v) begin
        shadow    <= pending;
        pending_v <= 1'b0;
      end
      if (xfer) begin
        pending   <= bus.load_data;
        pending_v <= 1'b1;
      end
    end
  end

  // Registered display drive: all digits off in BLANK, one digit on in SHOW.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.nibble_out <= '0;
      bus.dec_blank  <= 1'b1;
      bus.digit_en   <= '0;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.frame_tick <= boundary;
      bus.nibble_out <= digit[idx];
      if (phase == PH_SHOW) begin
        bus.digit_en  <= N_DIGITS'(1) << idx;
        bus.dec_blank <= bus.blank_mask[idx] | lz_cur;
      end else begin
        bus.digit_en  <= '0;
        bus.dec_blank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Frame-by-frame directed bench for seg7_scan_ctrl (N_DIGITS=4, CLK_DIV=8, BLANK_CYC=2).
module tb_seg7_scan_ctrl;

  logic clk;
  logic reset;

  seg7_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  seg7_scan_ctrl #(
    .N_DIGITS  (4),
    .CLK_DIV   (8),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // One record per 32-cycle frame: inputs applied during the frame and the
  // value / per-digit SHOW-phase dec_blank expected on the display.
  typedef struct {
    logic        lz;
    logic [3:0]  mask;
    int          load_k;
    logic [15:0] load_val;
    int          load2_k;
    logic [15:0] load2_val;
    logic [15:0] exp_val;
    logic [3:0]  exp_blank;
  } frame_t;

  frame_t tbl [13];
  int     checks;
  int     errors;
  logic   pend_exp;

  task automatic chk(input string nm, input int fi, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s frame=%0d cyc=%0d got=%0h want=%0h", nm, fi, k, act, exp);
    end
  endtask

  // Frame starts with the timer at cnt=0, idx=0; sample k reflects cnt=(k-1)%8 of digit (k-1)/8.
  task automatic run_frame(input frame_t f, input int fi);
    logic drv;
    logic old;
    int   d;
    int   ph;
    logic [3:0] en_exp;
    logic       bl_exp;
    bus.lz_suppress = f.lz;
    bus.blank_mask  = f.mask;
    for (int k = 1; k <= 32; k++) begin
      drv = 1'b0;
      if (f.load_k == k) begin
        bus.load_valid = 1'b1;
        bus.load_data  = f.load_val;
        drv = 1'b1;
      end else if (f.load2_k == k) begin
        bus.load_valid = 1'b1;
        bus.load_data  = f.load2_val;
        drv = 1'b1;
      end
      old = pend_exp;
      if (k == 32 && old) pend_exp = 1'b0;
      if (drv && !old) pend_exp = 1'b1;
      @(negedge clk);
      bus.load_valid = 1'b0;
      d  = (k - 1) / 8;
      ph = (k - 1) % 8;
      en_exp = (ph >= 2) ? (4'b0001 << d) : 4'b0000;
      bl_exp = (ph >= 2) ? f.exp_blank[d] : 1'b1;
      chk("digit_en",   fi, k, 32'(bus.digit_en),   32'(en_exp));
      chk("dec_blank",  fi, k, 32'(bus.dec_blank),  32'(bl_exp));
      chk("nibble_out", fi, k, 32'(bus.nibble_out), 32'(f.exp_val[4*d +: 4]));
      chk("frame_tick", fi, k, 32'(bus.frame_tick), 32'(k == 32));
      chk("load_ready", fi, k, 32'(bus.load_ready), 32'(!pend_exp));
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    pend_exp = 1'b0;

    //         lz    mask     ldk  ldval    ld2k ld2val   exp_val  exp_blank
    tbl[0]  = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'h0000, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0000, 10, 16'h12A4, 0,  16'h0000, 16'h0000, 4'b0000};
    tbl[2]  = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'h12A4, 4'b0000};
    tbl[3]  = '{1'b1, 4'b0000, 5,  16'h0005, 0,  16'h0000, 16'h12A4, 4'b0000};
    tbl[4]  = '{1'b1, 4'b0000, 5,  16'h0000, 0,  16'h0000, 16'h0005, 4'b1110};
    tbl[5]  = '{1'b1, 4'b0000, 5,  16'h0105, 0,  16'h0000, 16'h0000, 4'b1110};
    tbl[6]  = '{1'b1, 4'b0000, 5,  16'h8888, 0,  16'h0000, 16'h0105, 4'b1000};
    tbl[7]  = '{1'b0, 4'b0100, 3,  16'hAAAA, 12, 16'hBBBB, 16'h8888, 4'b0100};
    tbl[8]  = '{1'b0, 4'b0000, 32, 16'h5A5A, 0,  16'h0000, 16'hAAAA, 4'b0000};
    tbl[9]  = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'hAAAA, 4'b0000};
    tbl[10] = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'h5A5A, 4'b0000};
    tbl[11] = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'h0000, 4'b0000};
    tbl[12] = '{1'b0, 4'b0000, 0,  16'h0000, 0,  16'h0000, 16'h0000, 4'b0000};

    reset           = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.blank_mask  = '0;
    bus.lz_suppress = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digit_en",   -1, 0, 32'(bus.digit_en),   32'h0);
    chk("rst_dec_blank",  -1, 0, 32'(bus.dec_blank),  32'h1);
    chk("rst_nibble_out", -1, 0, 32'(bus.nibble_out), 32'h0);
    chk("rst_frame_tick", -1, 0, 32'(bus.frame_tick), 32'h0);
    chk("rst_load_ready", -1, 0, 32'(bus.load_ready), 32'h1);
    reset = 1'b0;

    for (int i = 0; i <= 10; i++) run_frame(tbl[i], i);

    // Reset in the middle of digit 2 with a load pending.
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h7777;
    @(negedge clk);
    bus.load_valid = 1'b0;
    chk("pend_ready", 99, 1, 32'(bus.load_ready), 32'h0);
    repeat (18) @(negedge clk);
    chk("pre_rst_digit_en", 99, 19, 32'(bus.digit_en), 32'h4);
    reset          = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h1234;
    @(negedge clk);
    chk("mid_rst_digit_en",   99, 20, 32'(bus.digit_en),   32'h0);
    chk("mid_rst_dec_blank",  99, 20, 32'(bus.dec_blank),  32'h1);
    chk("mid_rst_nibble_out", 99, 20, 32'(bus.nibble_out), 32'h0);
    chk("mid_rst_frame_tick", 99, 20, 32'(bus.frame_tick), 32'h0);
    chk("mid_rst_load_ready", 99, 20, 32'(bus.load_ready), 32'h1);
    @(negedge clk);
    chk("rst_ignores_load", 99, 21, 32'(bus.load_ready), 32'h1);
    bus.load_valid = 1'b0;
    reset          = 1'b0;
    pend_exp       = 1'b0;

    for (int i = 11; i <= 12; i++) run_frame(tbl[i], i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
